// File: rtl/priority_encoder_q.sv
// Queued N-input request encoder: coalesces request pulses into a pending set
// and grants one binary index per cycle over a valid/ready handshake.
module priority_encoder_q #(
  parameter int N       = 8,
  parameter int RR_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_in,
  input  logic                 clr,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [$clog2(N)-1:0] out_idx,
  output logic [N-1:0]         pending,
  output logic                 overflow
);

  localparam int W = $clog2(N);
  localparam logic [N-1:0] ONE  = N'(1);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] cand;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_idx_q, out_idx_d;
  logic         overflow_q, overflow_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] sel_fixed, sel_rr, sel;
  logic         rr_found;
  logic         load;

  // Same-cycle requests bypass the queue so an idle encoder grants in one edge.
  assign cand = pending_q | req_in;
  assign load = !out_valid_q || out_ready;

  always_comb begin
    sel_fixed = '0;
    for (int i = 0; i < N; i++) begin
      if (cand[i]) sel_fixed = W'(i);
    end
  end

  always_comb begin
    int j;
    j        = 0;
    sel_rr   = '0;
    rr_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_q) + k) % N;
      if (!rr_found && cand[j]) begin
        sel_rr   = W'(j);
        rr_found = 1'b1;
      end
    end
  end

  assign sel = (RR_MODE != 0) ? sel_rr : sel_fixed;

  always_comb begin
    pending_d   = pending_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    overflow_d  = overflow_q;
    ptr_d       = ptr_q;
    if (clr) begin
      pending_d   = '0;
      out_valid_d = 1'b0;
      overflow_d  = 1'b0;
      ptr_d       = '0;
    end else begin
      // A request landing on an already-queued bit is coalesced and lost.
      overflow_d = overflow_q | (|(req_in & pending_q));
      if (load) begin
        if (|cand) begin
          out_idx_d   = sel;
          out_valid_d = 1'b1;
          pending_d   = cand & ~(ONE << sel);
          if (RR_MODE != 0) begin
            ptr_d = (sel == LAST) ? '0 : sel + 1'b1;
          end
        end else begin
          out_valid_d = 1'b0;
          pending_d   = '0;
        end
      end else begin
        pending_d = pending_q | req_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      overflow_q  <= 1'b0;
      ptr_q       <= '0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      overflow_q  <= overflow_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_priority_encoder_q.sv
// Scoreboard bench for priority_encoder_q: one fixed-priority and one
// round-robin instance, expected grants queued at stimulus time.
module tb_priority_encoder_q;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_f, req_r;
  logic       clr_f, clr_r, rdy_f, rdy_r;
  logic       v_f, v_r, ovf_f, ovf_r;
  logic [2:0] idx_f, idx_r;
  logic [7:0] pend_f, pend_r;

  int checks   = 0;
  int failures = 0;
  int q_f[$];
  int q_r[$];

  always #5 clk = ~clk;

  priority_encoder_q #(.N(8), .RR_MODE(0)) dut_f (
    .clk(clk), .rst(rst), .req_in(req_f), .clr(clr_f), .out_ready(rdy_f),
    .out_valid(v_f), .out_idx(idx_f), .pending(pend_f), .overflow(ovf_f)
  );

  priority_encoder_q #(.N(8), .RR_MODE(1)) dut_r (
    .clk(clk), .rst(rst), .req_in(req_r), .clr(clr_r), .out_ready(rdy_r),
    .out_valid(v_r), .out_idx(idx_r), .pending(pend_r), .overflow(ovf_r)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // A transfer happens on the next edge whenever valid && ready is seen here.
  always @(negedge clk) begin
    if (!rst && v_f && rdy_f) begin
      if (q_f.size() == 0) chk("f_unexpected_grant", {29'd0, idx_f}, 32'hFFFF_FFFF);
      else chk("f_grant", {29'd0, idx_f}, q_f.pop_front());
    end
    if (!rst && v_r && rdy_r) begin
      if (q_r.size() == 0) chk("r_unexpected_grant", {29'd0, idx_r}, 32'hFFFF_FFFF);
      else chk("r_grant", {29'd0, idx_r}, q_r.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req_f = '0; req_r = '0;
    clr_f = 1'b0; clr_r = 1'b0;
    rdy_f = 1'b1; rdy_r = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, v_f}, 0);
    chk("rst_idx", {29'd0, idx_f}, 0);
    chk("rst_pending", {24'd0, pend_f}, 0);
    chk("rst_overflow", {31'd0, ovf_f}, 0);
    rst = 1'b0;
    tick(2);

    // fixed priority drains a burst highest first
    q_f.push_back(7); q_f.push_back(4); q_f.push_back(1);
    req_f = 8'b1001_0010;
    tick();
    req_f = '0;
    tick(3);
    chk("t1_valid_low", {31'd0, v_f}, 0);
    chk("t1_overflow", {31'd0, ovf_f}, 0);
    chk("t1_drain", q_f.size(), 0);

    // backpressure, re-queue of held index, then overflow
    rdy_f = 1'b0;
    req_f = 8'h80;
    tick();
    req_f = 8'h80;
    tick();
    chk("t2_idx_held", {29'd0, idx_f}, 7);
    chk("t2_pending", {24'd0, pend_f}, 8'h80);
    chk("t2_no_ovf", {31'd0, ovf_f}, 0);
    req_f = 8'h80;
    tick();
    req_f = '0;
    chk("t2_ovf_set", {31'd0, ovf_f}, 1);
    chk("t2_idx_still", {29'd0, idx_f}, 7);
    q_f.push_back(7); q_f.push_back(7);
    rdy_f = 1'b1;
    tick(3);
    chk("t2_valid_low", {31'd0, v_f}, 0);
    chk("t2_ovf_sticky", {31'd0, ovf_f}, 1);
    chk("t2_drain", q_f.size(), 0);
    clr_f = 1'b1;
    tick();
    clr_f = 1'b0;
    chk("t2_ovf_cleared", {31'd0, ovf_f}, 0);

    // stall keeps the held index while a higher request waits
    rdy_f = 1'b0;
    req_f = 8'h04;
    tick();
    req_f = 8'h20;
    tick();
    req_f = '0;
    tick();
    chk("t4_idx_stable", {29'd0, idx_f}, 2);
    chk("t4_valid", {31'd0, v_f}, 1);
    chk("t4_pending", {24'd0, pend_f}, 8'h20);
    q_f.push_back(2); q_f.push_back(5);
    rdy_f = 1'b1;
    tick(3);
    chk("t4_valid_low", {31'd0, v_f}, 0);
    chk("t4_drain", q_f.size(), 0);

    // clr beats a same-cycle request burst
    rdy_f = 1'b0;
    req_f = 8'h03;
    tick();
    req_f = 8'h03;
    tick();
    chk("t5_ovf_pre", {31'd0, ovf_f}, 1);
    req_f = 8'hFF;
    clr_f = 1'b1;
    tick();
    req_f = '0;
    clr_f = 1'b0;
    chk("t5_valid", {31'd0, v_f}, 0);
    chk("t5_pending", {24'd0, pend_f}, 0);
    chk("t5_overflow", {31'd0, ovf_f}, 0);
    rdy_f = 1'b1;
    tick(2);
    chk("t5_no_grant", {31'd0, v_f}, 0);

    // round-robin pointer advance and wrap
    q_r.push_back(1); q_r.push_back(2);
    req_r = 8'h06;
    tick();
    req_r = '0;
    tick(3);
    q_r.push_back(3); q_r.push_back(0);
    req_r = 8'h09;
    tick();
    req_r = '0;
    tick(3);
    q_r.push_back(1); q_r.push_back(7);
    req_r = 8'h82;
    tick();
    req_r = '0;
    tick(3);
    q_r.push_back(0); q_r.push_back(7);
    req_r = 8'h81;
    tick();
    req_r = '0;
    tick(3);
    chk("t3_valid_low", {31'd0, v_r}, 0);
    chk("t3_drain", q_r.size(), 0);

    // async reset during a stall discards everything
    rdy_f = 1'b0;
    req_f = 8'h80;
    tick();
    req_f = 8'h33;
    tick();
    req_f = '0;
    chk("t6_pending_pre", {24'd0, pend_f}, 8'h33);
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", {31'd0, v_f}, 0);
    chk("t6_idx", {29'd0, idx_f}, 0);
    chk("t6_pending", {24'd0, pend_f}, 0);
    chk("t6_overflow", {31'd0, ovf_f}, 0);
    #2 rst = 1'b0;
    tick();
    rdy_f = 1'b1;
    tick(3);
    chk("t6_no_replay", {31'd0, v_f}, 0);
    q_f.push_back(0);
    req_f = 8'h01;
    tick();
    req_f = '0;
    tick(2);
    chk("t6_valid_low", {31'd0, v_f}, 0);
    chk("t6_drain", q_f.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
